csa_slice_seq_ctrl: RTL and testbench
=====================================

Name: csa_slice_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a TOTAL_WIDTH-bit addition by time-sharing one SLICE_WIDTH-bit carry-select adder slice.
- Processes the operand one slice per cycle, LSB slice first, and registers each slice's carry-out into the next slice's carry-in.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width combinational carry-select adder.

Parameters:
- TOTAL_WIDTH, 28, operand and result width; must be an integer multiple of SLICE_WIDTH.
- SLICE_WIDTH, 7, width of the shared adder slice.
- NUM_SLICES, TOTAL_WIDTH/SLICE_WIDTH, derived localparam; must be ≥2.
- CNT_W, clog2(NUM_SLICES) (minimum 1), derived localparam for the slice counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_add_term1  input  TOTAL_WIDTH  operand A.
- i_add_term2  input  TOTAL_WIDTH  operand B.
- i_cin  input  1  carry-in to slice 0.
- i_abort  input  1  synchronous abort of the current operation.
- o_valid  output  1  result valid.
- i_res_ready  input  1  consumer accepts result.
- o_sum  output  TOTAL_WIDTH  registered sum.
- o_cout  output  1  registered carry-out of the last slice.
- o_busy  output  1  high in RUN or DONE.
- o_slice_idx  output  CNT_W  index of the slice being processed (debug).

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, i_rst=1): state=IDLE. o_sum=0, o_cout=0, o_valid=0, o_busy=0, o_slice_idx=0, internal carry=0, operand registers=0. o_ready is 0 while i_rst is high and 1 on the first cycle after release.
- o_ready = (state==IDLE) && !i_rst. o_valid = (state==DONE). o_busy = (state!=IDLE).
- IDLE: on i_valid && o_ready:
  - latch both operands and i_cin into the carry register; clear o_sum and o_cout;
  - set counter=0 and go to RUN.
  - i_valid is ignored in every other state; operands are not sampled again until IDLE.
- RUN, each cycle:
  - slice k = counter; slice input a = A[k*SW +: SW], b = B[k*SW +: SW], c = carry register;
  - {c_out, s} = a + b + c;
  - o_sum[k*SW +: SW] <= s; carry <= c_out; counter <= counter+1.
  - When k == NUM_SLICES-1: o_cout <= c_out, counter <= 0, go to DONE.
  - The slice adder is combinational inside this block; no other path combines slices.
- Latency: handshake on edge t puts the result and o_valid on edge t+NUM_SLICES (edge t+4 at defaults).
- DONE: o_sum and o_cout are held stable. On i_res_ready, go to IDLE; o_ready is high on the next cycle.
- Throughput: one operation per NUM_SLICES+2 cycles at best (one IDLE cycle between consecutive operations).
- Intermediate visibility: o_sum may show partially written slices during RUN; consumers must use it only when o_valid is high.
- i_abort: in RUN or DONE, i_abort=1 at an edge forces IDLE and counter=0. o_sum and o_cout keep their contents, o_valid drops, and no result is delivered. In IDLE, i_abort=1 blocks acceptance that cycle (abort has priority over i_valid).
- Simultaneous i_abort and i_res_ready in DONE: abort wins (same next state; counts as not delivered).
- Reset mid-operation returns to IDLE immediately with all outputs at their reset values. The in-flight operation is lost.
- Arithmetic is unsigned modulo 2^TOTAL_WIDTH; the carry out of the MSB slice appears only on o_cout.

Test Plan:
- Reset then idle: i_rst pulse, i_valid=0 -> o_ready=1, o_valid=0, o_sum=0, o_cout=0, o_busy=0 indefinitely.
- Basic add: A=0x0000123, B=0x0000456, cin=0 -> o_valid exactly 4 edges after the accept edge, o_sum=0x0000579, o_cout=0.
- Full carry ripple across slices: A=0xFFFFFFF, B=0x0000000, cin=1 -> o_sum=0x0000000, o_cout=1. Slice carry=1 after every RUN cycle; o_slice_idx steps 0,1,2,3.
- Back-pressure: A=0x8000000, B=0x8000000; hold i_res_ready=0 for 10 cycles -> o_sum=0x0000000, o_cout=1 stable; o_ready=0 throughout; i_valid pulses ignored; release -> IDLE next cycle.
- Abort at slice 2 (o_slice_idx=2) -> IDLE next edge, o_valid never asserts. The following op A=1, B=2 -> o_sum=0x0000003, o_cout=0, with no stale carry.
- Async reset asserted in RUN between clock edges -> outputs clear immediately without a clock edge; after release, A=0x7FFFFFF, B=1 -> o_sum=0x8000000, o_cout=0.

Source files
------------

// File: rtl/csa_slice_seq_ctrl_if.sv
// Operand/result handshake bundle for the time-shared carry-select adder sequencer.
// master = operand producer / result consumer side, slave = the sequencer.
interface csa_slice_seq_ctrl_if #(
  parameter int TOTAL_WIDTH = 28,
  parameter int CNT_W       = 2
);
  // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
  logic                   i_valid;
  logic                   o_ready;
  logic [TOTAL_WIDTH-1:0] i_add_term1;
  logic [TOTAL_WIDTH-1:0] i_add_term2;
  logic                   i_cin;
  logic                   i_abort;
  logic                   o_valid;
  logic                   i_res_ready;
  logic [TOTAL_WIDTH-1:0] o_sum;
  logic                   o_cout;
  logic                   o_busy;
  logic [CNT_W-1:0]       o_slice_idx;
  logic [1:0]             o_state;

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_abort, i_res_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_busy, o_slice_idx, o_state
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_abort, i_res_ready,
    output o_ready, o_valid, o_sum, o_cout, o_busy, o_slice_idx, o_state
  );
endinterface

// File: rtl/csa_slice_seq_ctrl.sv
// Multi-cycle TOTAL_WIDTH-bit adder: one SLICE_WIDTH carry-select slice reused LSB-first,
// the slice carry-out registered into the next slice's carry-in.
module csa_slice_seq_ctrl #(
  parameter int TOTAL_WIDTH = 28,
  parameter int SLICE_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  csa_slice_seq_ctrl_if.slave   bus
);
  localparam int NUM_SLICES = TOTAL_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 2) ? $clog2(NUM_SLICES) : 1;
  localparam int SW         = SLICE_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TOTAL_WIDTH-1:0] a_q, a_d;
  logic [TOTAL_WIDTH-1:0] b_q, b_d;
  logic [TOTAL_WIDTH-1:0] sum_q, sum_d;
  logic                   cout_q, cout_d;
  logic                   carry_q, carry_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   accept;
  logic                   last_slice;
  logic [SW-1:0]          a_sl [NUM_SLICES];
  logic [SW-1:0]          b_sl [NUM_SLICES];
  logic [SW-1:0]          slice_a, slice_b, slice_s;
  logic [SW:0]            sum_c0, sum_c1;
  logic                   slice_cout;

  // Abort takes priority over a new operand in IDLE.
  assign accept     = (state_q == S_IDLE) && bus.i_valid && !bus.i_abort;
  assign last_slice = (cnt_q == LAST_IDX);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (bus.i_abort)     state_d = S_IDLE;
        else if (last_slice) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.i_abort || bus.i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.o_ready     = (state_q == S_IDLE) && !i_rst;
    bus.o_valid     = (state_q == S_DONE);
    bus.o_busy      = (state_q != S_IDLE);
    bus.o_state     = state_q;
    bus.o_slice_idx = cnt_q;
    bus.o_sum       = sum_q;
    bus.o_cout      = cout_q;
  end

  // ---------------- shared carry-select slice ----------------
  for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slices
    assign a_sl[g] = a_q[g*SW +: SW];
    assign b_sl[g] = b_q[g*SW +: SW];
  end

  assign slice_a = a_sl[cnt_q];
  assign slice_b = b_sl[cnt_q];

  // Both carry-in hypotheses are formed in parallel; the registered carry only picks one.
  always_comb begin
    sum_c0 = {1'b0, slice_a} + {1'b0, slice_b};
    sum_c1 = sum_c0 + (SW+1)'(1);
    {slice_cout, slice_s} = carry_q ? sum_c1 : sum_c0;
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = bus.i_add_term1;
          b_d     = bus.i_add_term2;
          carry_d = bus.i_cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.i_abort) begin
          cnt_d = '0;
        end else begin
          for (int k = 0; k < NUM_SLICES; k++) begin
            if (CNT_W'(k) == cnt_q) sum_d[k*SW +: SW] = slice_s;
          end
          carry_d = slice_cout;
          if (last_slice) begin
            cout_d = slice_cout;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.i_abort) cnt_d = '0;
      end
      default: cnt_d = '0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_csa_slice_seq_ctrl.sv
// Directed bench for csa_slice_seq_ctrl: hand-computed sums, latency, back-pressure, abort, async reset.
module tb_csa_slice_seq_ctrl;
  localparam int TW    = 28;
  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [TW:0] exp_q[$];

  csa_slice_seq_ctrl_if #(.TOTAL_WIDTH(TW), .CNT_W(CNT_W)) bus ();

  csa_slice_seq_ctrl #(.TOTAL_WIDTH(TW), .SLICE_WIDTH(7)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.i_valid     = 1'b0;
    bus.i_add_term1 = '0;
    bus.i_add_term2 = '0;
    bus.i_cin       = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_res_ready = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (bus.o_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  // Accept on a posedge, leaving the bench at that posedge + 1.
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin);
    bus.i_add_term1 = a;
    bus.i_add_term2 = b;
    bus.i_cin       = cin;
    bus.i_valid     = 1'b1;
    @(posedge clk);
    #1 bus.i_valid  = 1'b0;
  endtask

  // Full operation: latency, slice index walk, result, optional hold and abort-on-release.
  task automatic run_op(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic cin, input logic [TW-1:0] es, input logic ec,
                        input int hold, input logic abort_on_release);
    logic [TW:0] exp;
    wait_ready(tag);
    send(a, b, cin);
    exp_q.push_back({ec, es});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_idx"},   32'(bus.o_slice_idx), 32'(k));
      check({tag, "_vlow"},  32'(bus.o_valid), 32'd0);
      check({tag, "_busy"},  32'(bus.o_busy), 32'd1);
      check({tag, "_rdylo"}, 32'(bus.o_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_sum"},  32'(bus.o_sum), 32'(exp[TW-1:0]));
      check({tag, "_cout"}, 32'(bus.o_cout), 32'(exp[TW]));
    end
    check({tag, "_idx0"}, 32'(bus.o_slice_idx), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.i_valid     = h[0];
      bus.i_add_term1 = 28'h1111111;
      bus.i_add_term2 = 28'h2222222;
      @(negedge clk);
      check({tag, "_hvalid"}, 32'(bus.o_valid), 32'd1);
      check({tag, "_hrdy"},   32'(bus.o_ready), 32'd0);
      check({tag, "_hsum"},   32'(bus.o_sum), 32'(es));
      check({tag, "_hcout"},  32'(bus.o_cout), 32'(ec));
    end
    bus.i_valid     = 1'b0;
    bus.i_res_ready = 1'b1;
    bus.i_abort     = abort_on_release;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    bus.i_abort     = 1'b0;
    check({tag, "_rel_rdy"},  32'(bus.o_ready), 32'd1);
    check({tag, "_rel_vld"},  32'(bus.o_valid), 32'd0);
    check({tag, "_rel_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_rel_sum"},  32'(bus.o_sum), 32'(es));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_busy",  32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(bus.o_ready), 32'd1);

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus.o_ready), 32'd1);
      check("idle_valid", 32'(bus.o_valid), 32'd0);
      check("idle_sum",   32'(bus.o_sum), 32'd0);
      check("idle_cout",  32'(bus.o_cout), 32'd0);
      check("idle_busy",  32'(bus.o_busy), 32'd0);
      check("idle_idx",   32'(bus.o_slice_idx), 32'd0);
    end

    run_op("basic",  28'h0000123, 28'h0000456, 1'b0, 28'h0000579, 1'b0, 0, 1'b0);
    run_op("ripple", 28'hFFFFFFF, 28'h0000000, 1'b1, 28'h0000000, 1'b1, 0, 1'b0);
    run_op("bp",     28'h8000000, 28'h8000000, 1'b0, 28'h0000000, 1'b1, 10, 1'b0);
    run_op("mix",    28'h5A5A5A5, 28'h3C3C3C3, 1'b1, 28'h9696969, 1'b0, 0, 1'b0);
    run_op("abrel",  28'h0000010, 28'h0000020, 1'b0, 28'h0000030, 1'b0, 1, 1'b1);

    // Abort in IDLE has priority over i_valid
    @(negedge clk);
    bus.i_abort     = 1'b1;
    bus.i_valid     = 1'b1;
    bus.i_add_term1 = 28'h0000001;
    @(negedge clk);
    bus.i_abort = 1'b0;
    bus.i_valid = 1'b0;
    check("idle_abort_busy", 32'(bus.o_busy), 32'd0);
    check("idle_abort_rdy",  32'(bus.o_ready), 32'd1);

    // Abort at slice 2, carry register holding 1 at that point
    wait_ready("abort");
    send(28'h0003FFF, 28'h0000081, 1'b0);
    begin
      int guard = 0;
      @(negedge clk);
      while (bus.o_slice_idx !== 2'd2 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      check("abort_reach_idx2", 32'(bus.o_slice_idx), 32'd2);
    end
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("abort_busy",  32'(bus.o_busy), 32'd0);
    check("abort_rdy",   32'(bus.o_ready), 32'd1);
    check("abort_idx",   32'(bus.o_slice_idx), 32'd0);
    check("abort_sum",   32'(bus.o_sum), 32'h0000080);
    check("abort_cout",  32'(bus.o_cout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_novalid", 32'(bus.o_valid), 32'd0);
    end
    run_op("post_abort", 28'h0000001, 28'h0000002, 1'b0, 28'h0000003, 1'b0, 0, 1'b0);

    // Async reset in RUN, between clock edges
    wait_ready("arst");
    send(28'h0000123, 28'h0000456, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("arst_pre_idx", 32'(bus.o_slice_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  32'(bus.o_busy), 32'd0);
    check("arst_sum",   32'(bus.o_sum), 32'd0);
    check("arst_idx",   32'(bus.o_slice_idx), 32'd0);
    check("arst_ready", 32'(bus.o_ready), 32'd0);
    check("arst_valid", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_rel_ready", 32'(bus.o_ready), 32'd1);
    run_op("post_rst", 28'h7FFFFFF, 28'h0000001, 1'b0, 28'h8000000, 1'b0, 0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
